ps2_key_port: RTL and testbench
===============================

// Module: ps2_key_port
// PURPOSE
//  Keyboard peripheral on the responder side of io_interface (key_io slot, CPU address 16'hFFFF).
//  Deserialises PS/2 device-to-host frames into scancode bytes.
//  Buffers bytes in a small FIFO and serves them on rdata.
//  CPU pops and clears flags by writing the slot. Reads have no side effects.
// PARAMETERS
//  FIFO_DEPTH  8      scancode entries buffered; power of two, >= 2
//  TIMEOUT     50000  clock cycles with no PS/2 falling edge before a partial frame is discarded
// PORTS
//  clock     in   1   system clock; also drives io_interface clock. One clock domain only.
//  reset     in   1   synchronous, active-high
//  io_waddr  in   16  io_interface waddr, already offset-relative (slot address 0)
//  io_wdata  in   16  io_interface wdata
//  io_wen    in   1   io_interface wenable, already decoded for this slot
//  io_rdata  out  16  io_interface rdata, combinational from registered state
//  ps2_clk   in   1   raw PS/2 clock pin, asynchronous
//  ps2_dat   in   1   raw PS/2 data pin, asynchronous
//  irq       out  1   high while FIFO not empty (registered)
// BEHAVIOUR
//  Reset: FIFO empty, all flags 0, frame FSM IDLE, synchronisers to 1, io_rdata=16'h0000, irq=0.
//  Reset mid-frame discards the partial frame. Reset overrides every same-cycle event.
//  Input conditioning
//   - ps2_clk and ps2_dat each pass a 2-FF synchroniser.
//   - Falling-edge pulse fe = prev_sync_clk & ~sync_clk.
//   - ps2_dat is sampled only on fe cycles.
//  Frame FSM (states IDLE, DATA, PARITY, STOP), 11-bit frame
//   - IDLE: fe & dat=0 -> DATA, bit count 0. fe & dat=1 (bad start) -> stay IDLE.
//   - DATA: shift LSB first. After the 8th bit -> PARITY.
//   - PARITY: latch bit -> STOP.
//   - STOP: on fe, frame good iff dat=1 and XOR(data, parity)=1 (odd parity). Always -> IDLE.
//   - Good frame: one-cycle push strobe on the cycle after the STOP fe.
//   - Bad parity or stop: no push, set ERR.
//   - Timeout: in any non-IDLE state, TIMEOUT cycles without fe -> IDLE, no push, ERR unchanged.
//     Counter clears on every fe.
//  FIFO
//   - Depth FIFO_DEPTH, 8-bit entries, wrapping read/write pointers.
//   - Count is $clog2(FIFO_DEPTH)+1 bits.
//   - Push when full: byte dropped, OVF set, contents unchanged.
//   - Pop when empty: no effect.
//   - Push and pop in the same cycle when non-empty and not full: both happen, count unchanged.
//   - Push and pop in the same cycle when full: pop first, push accepted, no OVF.
//   - Push and pop in the same cycle when empty: push accepted, pop ignored.
//  Register map (single slot, waddr==0; writes to other waddr are ignored)
//   - io_rdata[15] = VALID (FIFO non-empty)
//   - io_rdata[14] = OVF (sticky)
//   - io_rdata[13] = ERR (sticky)
//   - io_rdata[12:8] = 0
//   - io_rdata[7:0] = head byte when VALID, else 8'h00
//   - Write: wdata[0]=1 pops the head; wdata[1]=1 clears OVF; wdata[2]=1 clears ERR.
//   - A clear and a same-cycle set of the same flag: set wins.
//  Latency
//   - Pushed byte is visible on io_rdata and irq 1 cycle after the push strobe.
//   - That is no more than 4 clocks after the stop-bit falling edge at the pin.
//   - A pop takes effect on io_rdata the cycle after the write.
// STRUCTURE
//  Package io_pkg:
//   - typedef enum ps2_state_t {IDLE, DATA, PARITY, STOP}
//   - localparams KEY_VALID_BIT=15, KEY_OVF_BIT=14, KEY_ERR_BIT=13
//   - localparams KEY_POP_BIT=0, KEY_CLR_OVF_BIT=1, KEY_CLR_ERR_BIT=2
//  Sub-module ps2_frame_rx: synchronisers, edge detect, FSM and timeout.
//   - Outputs: byte_out[7:0], byte_stb, frame_err_stb.
//  Top level holds the FIFO, flags and register decode.
// TESTING (50 MHz clock, PS/2 bit period 80 us driven by the bench)
//  1. Frame 0x1C, parity 0, stop 1 -> io_rdata=16'h801C within 4 clks of the stop edge; irq=1.
//     Then write wdata=1 -> io_rdata=16'h0000, irq=0.
//  2. 0x1C with parity bit 1 -> no push; io_rdata=16'h2000. Write wdata=4 -> 16'h0000.
//  3. Nine good frames 0x01..0x09, no pops -> rdata=16'hC001.
//     Eight pops return 01..08 in order; the 9th byte was dropped; OVF stays set until wdata=2.
//  4. Send 4 bits, then idle 60000 clks, then full frame 0x5A -> only 0x5A queued; ERR=0.
//  5. FIFO full, pop write in the same cycle as the push strobe of 0x77
//     -> count stays 8, 0x77 at tail, OVF=0.
//  6. Assert reset mid-DATA, release, send frame 0xF0 -> io_rdata=16'h80F0; no stale bits.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types and register-bit positions for the io_interface keyboard slot.
package io_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    localparam int KEY_VALID_BIT   = 15;
    localparam int KEY_OVF_BIT     = 14;
    localparam int KEY_ERR_BIT     = 13;

    localparam int KEY_POP_BIT     = 0;
    localparam int KEY_CLR_OVF_BIT = 1;
    localparam int KEY_CLR_ERR_BIT = 2;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, falling-edge detect,
// 11-bit frame FSM with inactivity timeout; emits one-cycle byte/error strobes.
module ps2_frame_rx
    import io_pkg::*;
#(
    parameter int TIMEOUT = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] byte_out,
    output logic       byte_stb,
    output logic       frame_err_stb
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic             clk_meta_q, clk_meta_d;
    logic             clk_sync_q, clk_sync_d;
    logic             clk_prev_q, clk_prev_d;
    logic             dat_meta_q, dat_meta_d;
    logic             dat_sync_q, dat_sync_d;
    ps2_state_t       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       byte_q, byte_d;
    logic             stb_q, stb_d;
    logic             err_q, err_d;
    logic             fe;

    always_comb begin
        clk_meta_d = ps2_clk;
        clk_sync_d = clk_meta_q;
        clk_prev_d = clk_sync_q;
        dat_meta_d = ps2_dat;
        dat_sync_d = dat_meta_q;
        fe         = clk_prev_q & ~clk_sync_q;

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = '0;
        byte_d    = byte_q;
        stb_d     = 1'b0;
        err_d     = 1'b0;

        if (state_q != IDLE) begin
            tmo_d = fe ? '0 : tmo_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fe && !dat_sync_q) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fe) begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fe) begin
                    parity_d = dat_sync_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fe) begin
                    state_d = IDLE;
                    // Odd parity across data and parity bit, plus a high stop bit.
                    if (dat_sync_q && ((^shift_q) ^ parity_q)) begin
                        byte_d = shift_q;
                        stb_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled partial frame is abandoned silently.
        if (state_q != IDLE && !fe && tmo_q == TMO_W'(TIMEOUT - 1)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            tmo_q      <= '0;
            stb_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_meta_q <= clk_meta_d;
            clk_sync_q <= clk_sync_d;
            clk_prev_q <= clk_prev_d;
            dat_meta_q <= dat_meta_d;
            dat_sync_q <= dat_sync_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tmo_q      <= tmo_d;
            stb_q      <= stb_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        shift_q  <= shift_d;
        parity_q <= parity_d;
        byte_q   <= byte_d;
    end

    assign byte_out      = byte_q;
    assign byte_stb      = stb_q;
    assign frame_err_stb = err_q;

endmodule

// File: rtl/ps2_key_port.sv
// Keyboard slot on io_interface: scancode FIFO, sticky OVF/ERR flags,
// status/data readback and write-to-pop/clear decode.
module ps2_key_port
    import io_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] io_waddr,
    input  logic [15:0] io_wdata,
    input  logic        io_wen,
    output logic [15:0] io_rdata,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       byte_out;
    logic             byte_stb;
    logic             frame_err_stb;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             irq_q, irq_d;

    logic             slot_wr, pop_req, clr_ovf, clr_err;
    logic             empty, full, do_pop, do_push, ovf_set;

    ps2_frame_rx #(
        .TIMEOUT(TIMEOUT)
    ) u_rx (
        .clock        (clock),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .byte_out     (byte_out),
        .byte_stb     (byte_stb),
        .frame_err_stb(frame_err_stb)
    );

    always_comb begin
        slot_wr = io_wen && (io_waddr == 16'h0000);
        pop_req = slot_wr && io_wdata[KEY_POP_BIT];
        clr_ovf = slot_wr && io_wdata[KEY_CLR_OVF_BIT];
        clr_err = slot_wr && io_wdata[KEY_CLR_ERR_BIT];

        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        do_pop  = pop_req && !empty;
        // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
        do_push = byte_stb && (!full || do_pop);
        ovf_set = byte_stb && full && !do_pop;

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = byte_out;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

        ovf_d = ovf_set | (ovf_q & ~clr_ovf);
        err_d = frame_err_stb | (err_q & ~clr_err);
        irq_d = (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        io_rdata              = 16'h0000;
        io_rdata[KEY_VALID_BIT] = !empty;
        io_rdata[KEY_OVF_BIT]   = ovf_q;
        io_rdata[KEY_ERR_BIT]   = err_q;
        if (!empty) begin
            io_rdata[7:0] = mem_q[rd_ptr_q];
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_ps2_key_port.sv
// Bench for ps2_key_port: directed table, multi-cycle corner sequences and
// randomized frames against a queue-based model of the keyboard slot.
module tb_ps2_key_port;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int HALF  = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] io_waddr, io_wdata, io_rdata;
    logic        io_wen, ps2_clk, ps2_dat, irq;

    always #10 clock = ~clock;

    ps2_key_port #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT   (TMO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .io_waddr(io_waddr),
        .io_wdata(io_wdata),
        .io_wen  (io_wen),
        .io_rdata(io_rdata),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .irq     (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_err = 1'b0;

    typedef struct {
        logic [7:0]  d;
        bit          bp;
        bit          bs;
        logic [15:0] exp_f;
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic [15:0] exp_w;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_rdata();
        logic [15:0] r;
        r = 16'h0000;
        r[15] = (mq.size() != 0);
        r[14] = m_ovf;
        r[13] = m_err;
        if (mq.size() != 0) r[7:0] = mq[0];
        return r;
    endfunction

    task automatic check_state(input string name);
        check(name, io_rdata, model_rdata());
        check({name, "_irq"}, {15'b0, irq}, {15'b0, mq.size() != 0});
    endtask

    task automatic model_push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic model_write(input logic [15:0] addr, input logic [15:0] data);
        if (addr == 16'h0000) begin
            if (data[0] && mq.size() != 0) void'(mq.pop_front());
            if (data[1]) m_ovf = 1'b0;
            if (data[2]) m_err = 1'b0;
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
        io_waddr = addr;
        io_wdata = data;
        io_wen   = 1'b1;
        @(negedge clock);
        io_wen   = 1'b0;
        io_wdata = 16'h0000;
        io_waddr = 16'h0000;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    // Leaves ps2_clk low right after the last requested falling edge.
    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = frame[i];
            wait_clks(HALF);
            ps2_clk = 1'b0;
            if (i < nbits - 1) begin
                wait_clks(HALF);
                ps2_clk = 1'b1;
            end
        end
    endtask

    task automatic end_frame();
        wait_clks(HALF);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bp, input bit bs);
        send_bits(mk_frame(d, bp, bs), 11);
        wait_clks(4);
        end_frame();
    endtask

    initial begin
        tbl[0] = '{8'h1C, 1'b1, 1'b0, 16'h2000, 16'h0000, 16'h0004, 16'h0000};
        tbl[1] = '{8'hA5, 1'b0, 1'b1, 16'h2000, 16'h0000, 16'h0004, 16'h0000};
        tbl[2] = '{8'h00, 1'b0, 1'b0, 16'h8000, 16'h0000, 16'h0001, 16'h0000};
        tbl[3] = '{8'hFF, 1'b0, 1'b0, 16'h80FF, 16'h0000, 16'h0001, 16'h0000};
        tbl[4] = '{8'h3C, 1'b0, 1'b0, 16'h803C, 16'h0005, 16'h0001, 16'h803C};
        tbl[5] = '{8'h44, 1'b0, 1'b0, 16'h803C, 16'h0000, 16'h0001, 16'h8044};
        tbl[6] = '{8'h12, 1'b1, 1'b0, 16'hA044, 16'h0000, 16'h0007, 16'h0000};

        ps2_clk  = 1'b1;
        ps2_dat  = 1'b1;
        io_wen   = 1'b0;
        io_waddr = 16'h0000;
        io_wdata = 16'h0000;
        reset    = 1'b1;
        wait_clks(3);
        check("reset_rdata", io_rdata, 16'h0000);
        check("reset_irq", {15'b0, irq}, 16'h0000);
        reset = 1'b0;
        wait_clks(5);

        // Good frame: visible within 4 clocks of the stop edge, then popped.
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11);
        wait_clks(4);
        check("t1_latency", io_rdata, 16'h801C);
        check("t1_irq", {15'b0, irq}, 16'h0001);
        end_frame();
        cpu_write(16'h0000, 16'h0001);
        check("t1_pop", io_rdata, 16'h0000);
        check("t1_pop_irq", {15'b0, irq}, 16'h0000);

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].d, tbl[i].bp, tbl[i].bs);
            check($sformatf("tbl%0d_frame", i), io_rdata, tbl[i].exp_f);
            check($sformatf("tbl%0d_irq", i), {15'b0, irq}, {15'b0, tbl[i].exp_f[15]});
            cpu_write(tbl[i].waddr, tbl[i].wdata);
            check($sformatf("tbl%0d_write", i), io_rdata, tbl[i].exp_w);
        end

        // Overflow: nine frames into an eight-deep FIFO.
        for (int b = 1; b <= 9; b++) begin
            send_frame(8'(b), 1'b0, 1'b0);
            model_push(8'(b));
        end
        check("t3_full", io_rdata, 16'hC001);
        check_state("t3_full_model");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_head%0d", i), {8'h00, io_rdata[7:0]}, 16'(i + 1));
            cpu_write(16'h0000, 16'h0001);
            model_write(16'h0000, 16'h0001);
        end
        check("t3_ovf_sticky", io_rdata, 16'h4000);
        cpu_write(16'h0000, 16'h0002);
        model_write(16'h0000, 16'h0002);
        check_state("t3_ovf_clr");

        // Partial frame abandoned by timeout, then a clean frame.
        send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 4);
        end_frame();
        wait_clks(TMO + 100);
        check("t4_idle", io_rdata, 16'h0000);
        send_frame(8'h5A, 1'b0, 1'b0);
        model_push(8'h5A);
        check("t4_frame", io_rdata, 16'h805A);
        cpu_write(16'h0000, 16'h0001);
        model_write(16'h0000, 16'h0001);
        check_state("t4_pop");

        // Full FIFO, pop coincides with the push strobe.
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h30 + 8'(i), 1'b0, 1'b0);
            model_push(8'h30 + 8'(i));
        end
        check_state("t5_full");
        send_bits(mk_frame(8'h77, 1'b0, 1'b0), 11);
        wait_clks(3);
        cpu_write(16'h0000, 16'h0001);
        model_write(16'h0000, 16'h0001);
        model_push(8'h77);
        end_frame();
        check("t5_after", io_rdata, 16'h8031);
        for (int i = 0; i < 8; i++) begin
            check_state($sformatf("t5_drain%0d", i));
            cpu_write(16'h0000, 16'h0001);
            model_write(16'h0000, 16'h0001);
        end
        check("t5_empty", io_rdata, 16'h0000);

        // Reset in the middle of a frame.
        send_bits(mk_frame(8'hA5, 1'b0, 1'b0), 4);
        reset = 1'b1;
        wait_clks(2);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
        check("t6_reset", io_rdata, 16'h0000);
        wait_clks(HALF);
        send_frame(8'hF0, 1'b0, 1'b0);
        model_push(8'hF0);
        check("t6_frame", io_rdata, 16'h80F0);
        cpu_write(16'h0000, 16'h0001);
        model_write(16'h0000, 16'h0001);
        check_state("t6_pop");

        for (int k = 0; k < 15; k++) begin
            logic [7:0]  d;
            int          r;
            bit          bp, bs;
            logic [15:0] wa, wd;
            d  = 8'($urandom);
            r  = $urandom_range(0, 9);
            bp = (r <= 1);
            bs = (r == 2);
            send_frame(d, bp, bs);
            if (bp || bs) m_err = 1'b1;
            else model_push(d);
            check_state($sformatf("rnd%0d_frame", k));
            if ($urandom_range(0, 2) != 0) begin
                wa = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 15)) : 16'h0000;
                wd = 16'($urandom_range(0, 7));
                cpu_write(wa, wd);
                model_write(wa, wd);
                check_state($sformatf("rnd%0d_write", k));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
